// File: rtl/ram4k_arbiter_if.sv
// Request/acknowledge bundle for the two requesters sharing one ram4k.
// master = requester side, slave = arbiter side.
interface ram4k_arbiter_if #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 12
);
    logic              req0;
    logic              we0;
    logic [AWIDTH-1:0] addr0;
    logic [WIDTH-1:0]  wdata0;
    logic              ack0;
    logic [WIDTH-1:0]  rdata0;

    logic              req1;
    logic              we1;
    logic [AWIDTH-1:0] addr1;
    logic [WIDTH-1:0]  wdata1;
    logic              ack1;
    logic [WIDTH-1:0]  rdata1;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, rdata0,
        input  ack1, rdata1
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, rdata0,
        output ack1, rdata1
    );
endinterface

// File: rtl/ram4k_arbiter.sv
// Round-robin arbiter giving two requesters single-access transactions on one ram4k.
// Each transaction is IDLE (grant) -> ACCESS (RAM cycle) -> DONE (ack pulse).
module ram4k_arbiter #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              reset,
    ram4k_arbiter_if.slave    bus,
    output logic [WIDTH-1:0]  ram_in,
    output logic [AWIDTH-1:0] ram_address,
    output logic              ram_load,
    input  logic [WIDTH-1:0]  ram_out
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last_grant;
    logic              r_winner;
    logic              r_we;
    logic [AWIDTH-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;
    logic              r_ack0;
    logic              r_ack1;
    logic [WIDTH-1:0]  r_rdata0;
    logic [WIDTH-1:0]  r_rdata1;

    logic              w_any_req;
    logic              w_pick;

    assign w_any_req = bus.req0 | bus.req1;
    // On a tie the port that did not win last time is chosen; otherwise the lone requester.
    assign w_pick    = (bus.req0 & bus.req1) ? ~r_last_grant : bus.req1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_next = ACCESS;
            ACCESS:  w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_winner     <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            if (r_state == IDLE && w_any_req) begin
                r_winner <= w_pick;
                r_we     <= w_pick ? bus.we1    : bus.we0;
                r_addr   <= w_pick ? bus.addr1  : bus.addr0;
                r_wdata  <= w_pick ? bus.wdata1 : bus.wdata0;
            end
            // ram_out is sampled on the same edge as a write, so writes return the old word.
            if (r_state == ACCESS) begin
                r_last_grant <= r_winner;
                if (r_winner) begin
                    r_rdata1 <= ram_out;
                    r_ack1   <= 1'b1;
                end else begin
                    r_rdata0 <= ram_out;
                    r_ack0   <= 1'b1;
                end
            end
        end
    end

    assign ram_address = r_addr;
    assign ram_in      = r_wdata;
    assign ram_load    = (r_state == ACCESS) & r_we & ~reset;

    assign bus.ack0   = r_ack0;
    assign bus.ack1   = r_ack1;
    assign bus.rdata0 = r_rdata0;
    assign bus.rdata1 = r_rdata1;
endmodule

// File: tb/tb_ram4k_arbiter.sv
// Directed bench for ram4k_arbiter with a behavioural 4K x 16 RAM attached.
module tb_ram4k_arbiter;
    localparam int WIDTH  = 16;
    localparam int AWIDTH = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [WIDTH-1:0]  ram_in;
    logic [WIDTH-1:0]  ram_out;
    logic [AWIDTH-1:0] ram_address;
    logic              ram_load;
    logic              mem_clr = 1'b1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram4k_arbiter_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) bus ();

    ram4k_arbiter #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .ram_in      (ram_in),
        .ram_address (ram_address),
        .ram_load    (ram_load),
        .ram_out     (ram_out)
    );

    logic [WIDTH-1:0] mem [0:(1<<AWIDTH)-1];

    assign ram_out = mem[ram_address];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AWIDTH); i++) mem[i] <= '0;
        end else if (ram_load) begin
            mem[ram_address] <= ram_in;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on one port: grant edge, ACCESS, ack, then back to IDLE.
    task automatic txn(input string tag, input bit port, input bit we,
                       input logic [AWIDTH-1:0] addr, input logic [WIDTH-1:0] wdata,
                       input logic [WIDTH-1:0] exp_rdata);
        int   lat;
        bit   got_ack;
        logic [WIDTH-1:0] rd;
        if (port) begin
            bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
        end else begin
            bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
        end
        lat     = 0;
        got_ack = 1'b0;
        while (!got_ack && lat < 10) begin
            tick();
            lat++;
            if (lat == 1) begin
                check_eq({tag, " ram_load"}, ram_load, we);
                check_eq({tag, " ram_address"}, ram_address, addr);
                if (we) check_eq({tag, " ram_in"}, ram_in, wdata);
            end
            got_ack = port ? bus.ack1 : bus.ack0;
        end
        rd = port ? bus.rdata1 : bus.rdata0;
        check_eq({tag, " latency"}, lat, 2);
        check_eq({tag, " rdata"}, rd, exp_rdata);
        check_eq({tag, " other ack"}, port ? bus.ack0 : bus.ack1, 1'b0);
        $display("txn %s port=%0d we=%0d addr=0x%03h wdata=0x%04h rdata=0x%04h latency=%0d",
                 tag, port, we, addr, wdata, rd, lat);
        if (port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        tick();
        check_eq({tag, " idle load"}, ram_load, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

        // 1: reset state
        reset = 1'b1;
        tick();
        tick();
        mem_clr = 1'b0;
        check_eq("rst ack0", bus.ack0, 1'b0);
        check_eq("rst ack1", bus.ack1, 1'b0);
        check_eq("rst rdata0", bus.rdata0, 16'h0000);
        check_eq("rst rdata1", bus.rdata1, 16'h0000);
        check_eq("rst ram_load", ram_load, 1'b0);
        check_eq("rst ram_address", ram_address, 12'h000);
        check_eq("rst ram_in", ram_in, 16'h0000);
        reset = 1'b0;

        // 2: write then read back on port 0
        txn("wr0_005", 1'b0, 1'b1, 12'h005, 16'h1234, 16'h0000);
        txn("rd0_005", 1'b0, 1'b0, 12'h005, 16'h0000, 16'h1234);

        // 3: both ports requesting continuously after reset
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.we0 = 1'b0; bus.addr0 = 12'h005;
        bus.we1 = 1'b0; bus.addr1 = 12'h0FF;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_eq($sformatf("rr ack0 k=%0d", k), bus.ack0, (k % 6) == 2);
            check_eq($sformatf("rr ack1 k=%0d", k), bus.ack1, (k % 6) == 5);
            if (bus.ack0) check_eq($sformatf("rr rdata0 k=%0d", k), bus.rdata0, 16'h1234);
            if (bus.ack1) check_eq($sformatf("rr rdata1 k=%0d", k), bus.rdata1, 16'h0000);
            if (bus.ack0 || bus.ack1)
                $display("txn rr k=%0d ack0=%0d ack1=%0d", k, bus.ack0, bus.ack1);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();

        // 4: top address, write returns old word, other writes do not disturb it
        txn("wr1_fff", 1'b1, 1'b1, 12'hFFF, 16'hBEEF, 16'h0000);
        txn("rd0_fff", 1'b0, 1'b0, 12'hFFF, 16'h0000, 16'hBEEF);
        txn("wr0_000", 1'b0, 1'b1, 12'h000, 16'hFFFF, 16'h0000);
        txn("rd1_fff", 1'b1, 1'b0, 12'hFFF, 16'h0000, 16'hBEEF);

        // 5: reset during ACCESS cancels the write and the ack
        txn("wr0_010", 1'b0, 1'b1, 12'h010, 16'h5555, 16'h0000);
        bus.we0 = 1'b1; bus.addr0 = 12'h010; bus.wdata0 = 16'hAAAA; bus.req0 = 1'b1;
        tick();
        check_eq("abort load before reset", ram_load, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("abort load in reset", ram_load, 1'b0);
        tick();
        check_eq("abort ack0", bus.ack0, 1'b0);
        check_eq("abort rdata0", bus.rdata0, 16'h0000);
        check_eq("abort ram_load", ram_load, 1'b0);
        $display("txn abort port=0 we=1 addr=0x010 wdata=0xaaaa cancelled by reset");
        reset = 1'b0;
        bus.req0 = 1'b0;
        tick();
        txn("rd0_010", 1'b0, 1'b0, 12'h010, 16'h0000, 16'h5555);

        // 6: port 0 streaming reads alternating between 0x000 and 0x001
        n = 0;
        bus.req1 = 1'b0;
        bus.we0 = 1'b0; bus.addr0 = 12'h000; bus.req0 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_eq($sformatf("stream ack0 k=%0d", k), bus.ack0, (k % 3) == 2);
            check_eq($sformatf("stream ack1 k=%0d", k), bus.ack1, 1'b0);
            check_eq($sformatf("stream load k=%0d", k), ram_load, 1'b0);
            if (bus.ack0) begin
                check_eq($sformatf("stream rdata0 n=%0d", n), bus.rdata0,
                         (n % 2 == 0) ? 16'hFFFF : 16'h0000);
                $display("txn stream n=%0d k=%0d rdata0=0x%04h", n, k, bus.rdata0);
                n++;
                bus.addr0 = (n % 2 == 0) ? 12'h000 : 12'h001;
            end
        end
        bus.req0 = 1'b0;
        check_eq("stream ack count", n, 4);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram4k_arbiter.md
Name: ram4k_arbiter

Overview:
Two-requester arbiter that shares one ram4k instance, e.g. CPU data port and a DMA/screen-refresh engine. It accepts requests on two identical request/acknowledge ports and picks a winner round-robin. It sequences exactly one RAM access per transaction and returns read data with a one-cycle acknowledge pulse. It is the only driver of the ram4k in, address and load inputs.

Parameters:
WIDTH, 16, data word width (matches ram4k word).
AWIDTH, 12, address width (4K words).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
req0  input  1  port 0 request; held until ack0.
we0  input  1  port 0 write enable (1 = write, 0 = read); stable while req0.
addr0  input  AWIDTH  port 0 address; stable while req0.
wdata0  input  WIDTH  port 0 write data; stable while req0.
ack0  output  1  one-cycle completion pulse for port 0.
rdata0  output  WIDTH  port 0 read data; valid when ack0=1, held until next port 0 ack.
req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
ram_in  output  WIDTH  to ram4k in.
ram_address  output  AWIDTH  to ram4k address.
ram_load  output  1  to ram4k load.
ram_out  input  WIDTH  from ram4k out; combinational read of mem[ram_address].

Behaviour:
- Reset (sync, active-high) gives:
  - state=IDLE, ack0=ack1=0, rdata0=rdata1=0.
  - last_grant=1, so port 0 wins the first tie.
  - ram_load=0.
- FSM states:
  - IDLE: if no req, stay in IDLE. If exactly one req, latch that port as the winner and go to ACCESS. If both req, latch the port that is not last_grant and go to ACCESS.
  - ACCESS (one cycle):
    - ram_address = winner addr; ram_in = winner wdata.
    - ram_load = winner we & ~reset.
    - At the rising edge: rdata_winner <= ram_out; last_grant <= winner; go to DONE.
  - DONE (one cycle): ack_winner=1 (registered), the other ack=0; next state IDLE.
- Latency: request sampled at edge N (IDLE) → ram_load/address in cycle N+1 → ack in cycle N+2.
- Throughput: at most one access per 3 cycles, even with continuous requests.
- Requester must drop req, or present a new transaction, in the cycle after ack. A req still high in IDLE is treated as a new request.
- Write transactions: rdata returns the word at the address before the write (ram_out is sampled in the same cycle as the write edge).
- Outside ACCESS:
  - ram_load=0.
  - ram_address and ram_in hold the last winner's values (0 after reset); no X.
- The winner's address, data and we are latched at grant. Changes on the req inputs after grant do not affect the transaction.
- Only a req asserted in IDLE is considered. The losing port keeps its req high and is granted in the next IDLE.
- Round-robin guarantees neither port waits more than one transaction of the other.
- Reset mid-operation:
  - Reset high during ACCESS suppresses ram_load (no write).
  - Any pending ack is cancelled; FSM returns to IDLE.
- Address wrap: none. Full 12-bit range 0x000–0xFFF is valid; no bounds logic.

Test Plan:
1. Assert reset 2 cycles → ack0=ack1=0, rdata0=rdata1=0, ram_load=0, state IDLE.
2. req0, we0=1, addr0=0x005, wdata0=0x1234 → ram_load=1 only in cycle N+1 with ram_address=0x005, ack0 in N+2; then req0 read 0x005 → rdata0=0x1234 at ack0.
3. After reset, req0 and req1 both held high, both reads → ack0 first, then ack1 3 cycles later, then alternating 0,1,0,1. Each port is acked every 6 cycles.
4. req1 writes 0x0FFF=0xBEEF → rdata1 = old value (0 if unwritten); then req0 reads 0x0FFF → rdata0=0xBEEF; req0 writes 0x000=0xFFFF does not disturb 0x0FFF.
5. req0 write 0x010=0xAAAA, assert reset in its ACCESS cycle → no ack0, ram_load low at that edge; subsequent read of 0x010 returns the prior value.
6. req0 held high continuously with req1=0, alternating addresses 0x000/0x001 → ack0 every 3 cycles, ack1 never, ram_load never asserted for reads.
